// File: rtl/input_pkg.sv
// Shared constants and priming-state encoding for the DE1-SoC input debouncer.
package input_pkg;

    localparam int DB_CYCLES_50MHZ_10MS = 500000;
    localparam int N_KEYS_DE1           = 4;
    localparam int N_SW_DE1             = 10;

    typedef enum logic [1:0] {
        RESET_WAIT,
        LOAD,
        RUN
    } prime_state_t;

endpackage

// File: rtl/input_debouncer_bit.sv
// One input bit: two-flop synchroniser, hold counter, accepted level and registered edge pulses.
module debounce_bit #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic load,
    input  logic run,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (load) begin
            stable_d = s2_q;
        end else if (run && (s2_q != stable_q)) begin
            // Counter only advances while the synchronised input disagrees; any agreement clears it.
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces DE1-SoC KEY/SW pins; a priming FSM loads initial levels without generating pulses.
module input_debouncer
    import input_pkg::*;
#(
    parameter int N_KEYS    = N_KEYS_DE1,
    parameter int N_SW      = N_SW_DE1,
    parameter int DB_CYCLES = DB_CYCLES_50MHZ_10MS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n_raw,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] keys_clean,
    output logic [N_SW-1:0]   sw_clean,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_toggle,
    output logic              primed
);

    localparam int CNT_W  = $clog2(DB_CYCLES);
    localparam int N_BITS = N_KEYS + N_SW;

    prime_state_t      state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic              load, run;
    logic [N_BITS-1:0] raw, level, rise, fall;

    // Keys are inverted ahead of the synchroniser so every bit reads 1 = active.
    assign raw = {sw_raw, ~key_n_raw};

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        load    = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            RESET_WAIT: begin
                if (wait_q == 2'd2) begin
                    state_d = LOAD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RESET_WAIT;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw[i]),
            .load    (load),
            .run     (run),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign primed      = (state_q == RUN);
    assign keys_clean  = level[N_KEYS-1:0];
    assign sw_clean    = level[N_BITS-1:N_KEYS];
    assign key_press   = rise[N_KEYS-1:0];
    assign key_release = fall[N_KEYS-1:0];
    assign sw_toggle   = rise[N_BITS-1:N_KEYS] | fall[N_BITS-1:N_KEYS];

endmodule

// File: tb/tb_input_debouncer.sv
// Directed and random-bounce checks of input_debouncer with a short debounce window.
module tb_input_debouncer;

    localparam int N_KEYS = 4;
    localparam int N_SW   = 10;
    localparam int DB     = 4;
    localparam int NB     = N_KEYS + N_SW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N_KEYS-1:0] key_n_raw;
    logic [N_SW-1:0]   sw_raw;
    logic [N_KEYS-1:0] keys_clean, key_press, key_release;
    logic [N_SW-1:0]   sw_clean, sw_toggle;
    logic              primed;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .N_KEYS    (N_KEYS),
        .N_SW      (N_SW),
        .DB_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n_raw   (key_n_raw),
        .sw_raw      (sw_raw),
        .keys_clean  (keys_clean),
        .sw_clean    (sw_clean),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_toggle   (sw_toggle),
        .primed      (primed)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sw_raw    = 10'h2A5;
        key_n_raw = 4'b1110;
        reset_n   = 1'b0;
        repeat (3) step();
        tests++;
        if ({primed, keys_clean, sw_clean, key_press, key_release, sw_toggle} !== 33'd0) begin
            fails++;
            $display("FAIL reset_state got primed=%b keys=%b sw=%h press=%b rel=%b tog=%h, expected all 0",
                     primed, keys_clean, sw_clean, key_press, key_release, sw_toggle);
        end
        reset_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            tests++;
            if (primed !== (e >= 3)) begin
                fails++;
                $display("FAIL prime_flag edge %0d got %b expected %b", e, primed, (e >= 3));
            end
            tests++;
            if (sw_clean !== ((e >= 3) ? 10'h2A5 : 10'h000) || keys_clean !== ((e >= 3) ? 4'b0001 : 4'b0000)) begin
                fails++;
                $display("FAIL prime_levels edge %0d got sw=%h keys=%b", e, sw_clean, keys_clean);
            end
            tests++;
            if ({key_press, key_release, sw_toggle} !== 18'd0) begin
                fails++;
                $display("FAIL prime_pulses edge %0d got press=%b rel=%b tog=%h expected 0",
                         e, key_press, key_release, sw_toggle);
            end
        end
    endtask

    task automatic test_clean_press();
        key_n_raw = 4'b1010;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests++;
            if (keys_clean !== ((k >= 6) ? 4'b0101 : 4'b0001) || key_press !== ((k == 6) ? 4'b0100 : 4'b0000)
                || key_release !== 4'b0000) begin
                fails++;
                $display("FAIL press cycle %0d got keys=%b press=%b rel=%b", k, keys_clean, key_press, key_release);
            end
        end
        key_n_raw = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests++;
            if (keys_clean !== ((k >= 6) ? 4'b0001 : 4'b0101) || key_release !== ((k == 6) ? 4'b0100 : 4'b0000)
                || key_press !== 4'b0000) begin
                fails++;
                $display("FAIL release cycle %0d got keys=%b press=%b rel=%b", k, keys_clean, key_press, key_release);
            end
        end
    endtask

    task automatic test_glitch();
        logic [6:0] pat = 7'b0101101;
        sw_raw[5] = 1'b0;
        repeat (8) step();
        tests++;
        if (sw_clean !== 10'h285) begin
            fails++;
            $display("FAIL glitch_setup got sw=%h expected 285", sw_clean);
        end
        sw_raw[5] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) sw_raw[5] = 1'b0;
            step();
            tests++;
            if (sw_clean !== 10'h285 || sw_toggle !== 10'h000) begin
                fails++;
                $display("FAIL glitch_reject cycle %0d got sw=%h tog=%h", k, sw_clean, sw_toggle);
            end
        end
        for (int k = 0; k < 7; k++) begin
            sw_raw[5] = pat[k];
            step();
            tests++;
            if (sw_clean !== 10'h285 || sw_toggle !== 10'h000) begin
                fails++;
                $display("FAIL bounce cycle %0d got sw=%h tog=%h", k, sw_clean, sw_toggle);
            end
        end
        sw_raw[5] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests++;
            if (sw_clean !== ((k >= 6) ? 10'h2A5 : 10'h285) || sw_toggle !== ((k == 6) ? 10'h020 : 10'h000)) begin
                fails++;
                $display("FAIL bounce_settle cycle %0d got sw=%h tog=%h", k, sw_clean, sw_toggle);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_n_raw = 4'b1111;
        repeat (8) step();
        tests++;
        if (keys_clean !== 4'b0000) begin
            fails++;
            $display("FAIL simul_setup got keys=%b expected 0000", keys_clean);
        end
        key_n_raw = 4'b0110;
        sw_raw[9] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests++;
            if (key_press !== ((k == 6) ? 4'b1001 : 4'b0000) || sw_toggle !== ((k == 6) ? 10'h200 : 10'h000)
                || key_release !== 4'b0000) begin
                fails++;
                $display("FAIL simul_pulses cycle %0d got press=%b tog=%h rel=%b", k, key_press, sw_toggle, key_release);
            end
            tests++;
            if (keys_clean !== ((k >= 6) ? 4'b1001 : 4'b0000) || sw_clean !== ((k >= 6) ? 10'h0A5 : 10'h2A5)) begin
                fails++;
                $display("FAIL simul_levels cycle %0d got keys=%b sw=%h", k, keys_clean, sw_clean);
            end
        end
    endtask

    task automatic test_reset_mid();
        sw_raw[0] = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        tests++;
        if ({primed, keys_clean, sw_clean, key_press, key_release, sw_toggle} !== 33'd0) begin
            fails++;
            $display("FAIL midreset_state got primed=%b keys=%b sw=%h press=%b rel=%b tog=%h, expected all 0",
                     primed, keys_clean, sw_clean, key_press, key_release, sw_toggle);
        end
        reset_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            tests++;
            if (primed !== (e >= 3) || sw_clean !== ((e >= 3) ? 10'h0A4 : 10'h000)
                || keys_clean !== ((e >= 3) ? 4'b1001 : 4'b0000)) begin
                fails++;
                $display("FAIL reprime edge %0d got primed=%b sw=%h keys=%b", e, primed, sw_clean, keys_clean);
            end
            tests++;
            if ({key_press, key_release, sw_toggle} !== 18'd0) begin
                fails++;
                $display("FAIL reprime_pulses edge %0d got press=%b rel=%b tog=%h", e, key_press, key_release, sw_toggle);
            end
        end
    endtask

    task automatic test_long_run();
        logic [NB-1:0] r, st, acc, rise_e, fall_e;
        logic [NB-1:0] hist [DB+2];
        r  = {sw_raw, ~key_n_raw};
        st = r;
        for (int j = 0; j < DB + 2; j++) hist[j] = r;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 1) == 0) r[$urandom_range(0, NB - 1)] ^= 1'b1;
            sw_raw    = r[NB-1:N_KEYS];
            key_n_raw = ~r[N_KEYS-1:0];
            step();
            for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = r;
            // A bit is accepted once the last DB synchronised samples all disagree with the held level.
            acc = '1;
            for (int j = 2; j < DB + 2; j++) acc &= hist[j] ^ st;
            rise_e = acc & ~st;
            fall_e = acc & st;
            st     = st ^ acc;
            tests++;
            if ({sw_clean, keys_clean} !== st || key_press !== rise_e[N_KEYS-1:0]
                || key_release !== fall_e[N_KEYS-1:0] || sw_toggle !== acc[NB-1:N_KEYS]) begin
                fails++;
                $display("FAIL long_run cycle %0d got lvl=%h press=%b rel=%b tog=%h expected lvl=%h press=%b rel=%b tog=%h",
                         c, {sw_clean, keys_clean}, key_press, key_release, sw_toggle,
                         st, rise_e[N_KEYS-1:0], fall_e[N_KEYS-1:0], acc[NB-1:N_KEYS]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
